// File: rtl/fadd_share_arbiter.sv
// Two-requester sequencer for one shared combinational single-precision adder.
// Operands are granted round-robin, held on fadd_a/fadd_b for SETTLE_CYCLES,
// then the adder output is registered and returned with the requester id.
//
// Handshake semantics (all channels): a transfer happens on a rising edge where
// valid && ready are both high. Producers keep valid and payload stable until
// the transfer; ready may depend combinationally on valid.
module fadd_share_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_data,
    output logic [31:0]      fadd_a,
    output logic [31:0]      fadd_b,
    input  logic [31:0]      fadd_y,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr_ptr;
    logic        gnt_id;
    logic [3:0]  settle_cnt;
    logic        grant;
    logic        any_valid;
    logic        accept;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_sub;

    // Arbitration: a lone requester wins, otherwise rr_ptr breaks the tie.
    // Ready is held low during reset so no transfer is ever signalled then.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        req0_ready = !reset && (state == IDLE) && any_valid && !grant;
        req1_ready = !reset && (state == IDLE) && any_valid && grant;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        sel_a      = grant ? req1_a   : req0_a;
        sel_b      = grant ? req1_b   : req0_b;
        sel_sub    = grant ? req1_sub : req0_sub;
    end

    // Next-state logic for the issue / settle / respond sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (settle_cnt == 4'd0) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath: latch operands on issue, capture the sum, retire the response.
    always_ff @(posedge clk) begin
        if (reset) begin
            fadd_a     <= '0;
            fadd_b     <= '0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
            resp_valid <= 1'b0;
            op_count   <= '0;
            rr_ptr     <= 1'b0;
            gnt_id     <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        fadd_a     <= sel_a;
                        // Subtraction is a raw sign flip, applied to every encoding.
                        fadd_b     <= {sel_b[31] ^ sel_sub, sel_b[30:0]};
                        gnt_id     <= grant;
                        settle_cnt <= 4'(SETTLE_CYCLES - 1);
                    end
                end
                EXEC: begin
                    if (settle_cnt == 4'd0) begin
                        resp_data  <= fadd_y;
                        resp_id    <= gnt_id;
                        resp_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + CNT_W'(1);
                        // The requester just served loses the next tie.
                        rr_ptr     <= ~gnt_id;
                    end
                end
                default: ;
            endcase
        end
    end

    // Busy doubles as the externally visible FSM status.
    assign busy = (state != IDLE);

endmodule
